// File: rtl/l2_arb_pkg.sv
// rtl/l2_arb_pkg.sv - shared types and constants for the two-core L2 bus arbiter
package l2_arb_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ISSUE     = 2'd1,
        WAIT_FILL = 2'd2,
        RESP      = 2'd3
    } state_t;

    localparam logic [6:0] OPC_LOAD  = 7'b0000011;
    localparam logic [6:0] OPC_STORE = 7'b0100011;

    localparam logic [1:0] L2_HIT  = 2'b10;
    localparam logic [1:0] L2_MISS = 2'b01;
    localparam logic [1:0] L2_NONE = 2'b00;

endpackage

// File: rtl/rr_pick2.sv
// rtl/rr_pick2.sv - two-way round-robin pick producing a one-hot winner
module rr_pick2 (
    input  logic [1:0] req,
    input  logic       rr_ptr,
    output logic [1:0] winner
);

    always_comb begin
        winner = 2'b00;
        if (req == 2'b11) begin
            winner = rr_ptr ? 2'b10 : 2'b01;
        end else begin
            winner = req;
        end
    end

endmodule

// File: rtl/l2_bus_arbiter.sv
// rtl/l2_bus_arbiter.sv - arbitrates two cores onto one L2 port, one transaction at a time
module l2_bus_arbiter
    import l2_arb_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  req,
    input  logic [13:0] req_opcode,
    input  logic [63:0] req_address,
    input  logic [63:0] req_wdata,
    output logic [1:0]  gnt,
    output logic [1:0]  done,
    output logic [1:0]  err,
    output logic [31:0] rdata,
    output logic        busy,
    output logic [6:0]  l2_opcode,
    output logic [31:0] l2_address,
    output logic [31:0] l2_wdata,
    input  logic [1:0]  l2_hit,
    input  logic [31:0] l2_rdata
);

    localparam logic [4:0] CNT_LAST = 5'(TIMEOUT_CYCLES - 1);

    state_t      state_q;
    logic        rr_ptr_q;
    logic        id_q;
    logic [4:0]  cnt_q;
    logic [31:0] data_q;
    logic        fail_q;
    logic [1:0]  gnt_q;
    logic [1:0]  done_q;
    logic [1:0]  err_q;
    logic [31:0] rdata_q;
    logic        busy_q;
    logic [6:0]  l2_opcode_q;
    logic [31:0] l2_address_q;
    logic [31:0] l2_wdata_q;

    logic [1:0]  winner_d;
    logic        is_load_d;
    logic        hit_d;
    logic        to_resp_d;

    rr_pick2 u_pick (
        .req    (req),
        .rr_ptr (rr_ptr_q),
        .winner (winner_d)
    );

    // The L2 drive registers double as the transaction latch: they hold the
    // granted request for ISSUE/WAIT_FILL and are zeroed on the way to RESP.
    always_comb begin
        is_load_d = (l2_opcode_q == OPC_LOAD);
        hit_d     = (l2_hit == L2_HIT);
        to_resp_d = 1'b0;
        case (state_q)
            ISSUE:     to_resp_d = !is_load_d || hit_d;
            WAIT_FILL: to_resp_d = hit_d || (cnt_q == CNT_LAST);
            default:   to_resp_d = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            rr_ptr_q     <= 1'b0;
            id_q         <= 1'b0;
            cnt_q        <= '0;
            data_q       <= '0;
            fail_q       <= 1'b0;
            gnt_q        <= '0;
            done_q       <= '0;
            err_q        <= '0;
            rdata_q      <= '0;
            busy_q       <= 1'b0;
            l2_opcode_q  <= '0;
            l2_address_q <= '0;
            l2_wdata_q   <= '0;
        end else begin
            gnt_q   <= '0;
            done_q  <= '0;
            err_q   <= '0;
            rdata_q <= '0;
            case (state_q)
                IDLE: begin
                    if (|req) begin
                        gnt_q        <= winner_d;
                        id_q         <= winner_d[1];
                        l2_opcode_q  <= winner_d[1] ? req_opcode[13:7]   : req_opcode[6:0];
                        l2_address_q <= winner_d[1] ? req_address[63:32] : req_address[31:0];
                        l2_wdata_q   <= winner_d[1] ? req_wdata[63:32]   : req_wdata[31:0];
                        data_q       <= '0;
                        fail_q       <= 1'b0;
                        busy_q       <= 1'b1;
                        state_q      <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (is_load_d) begin
                        case (l2_hit)
                            L2_HIT:  data_q <= l2_rdata;
                            L2_MISS: begin
                                cnt_q   <= '0;
                                state_q <= WAIT_FILL;
                            end
                            L2_NONE: ;
                            default: ;
                        endcase
                    end
                end
                WAIT_FILL: begin
                    cnt_q <= cnt_q + 5'd1;
                    // A fill arriving on the timeout cycle still counts as a hit.
                    if (hit_d) begin
                        data_q <= l2_rdata;
                    end else if (cnt_q == CNT_LAST) begin
                        fail_q <= 1'b1;
                    end
                end
                RESP: begin
                    done_q   <= id_q ? 2'b10 : 2'b01;
                    err_q    <= fail_q ? (id_q ? 2'b10 : 2'b01) : 2'b00;
                    rdata_q  <= data_q;
                    rr_ptr_q <= ~id_q;
                    busy_q   <= 1'b0;
                    state_q  <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
            if (to_resp_d) begin
                state_q      <= RESP;
                l2_opcode_q  <= '0;
                l2_address_q <= '0;
                l2_wdata_q   <= '0;
            end
        end
    end

    assign gnt        = gnt_q;
    assign done       = done_q;
    assign err        = err_q;
    assign rdata      = rdata_q;
    assign busy       = busy_q;
    assign l2_opcode  = l2_opcode_q;
    assign l2_address = l2_address_q;
    assign l2_wdata   = l2_wdata_q;

endmodule

// File: tb/tb_l2_bus_arbiter.sv
// tb/tb_l2_bus_arbiter.sv - self-checking bench for l2_bus_arbiter
module tb_l2_bus_arbiter;

    localparam logic [6:0] LD  = 7'b0000011;
    localparam logic [6:0] ST  = 7'b0100011;
    localparam logic [6:0] ALU = 7'b0010011;
    localparam int         TO  = 16;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  req;
    logic [13:0] req_opcode;
    logic [63:0] req_address;
    logic [63:0] req_wdata;
    logic [1:0]  gnt;
    logic [1:0]  done;
    logic [1:0]  err;
    logic [31:0] rdata;
    logic        busy;
    logic [6:0]  l2_opcode;
    logic [31:0] l2_address;
    logic [31:0] l2_wdata;
    logic [1:0]  l2_hit;
    logic [31:0] l2_rdata;

    l2_bus_arbiter #(.TIMEOUT_CYCLES(TO)) dut (
        .clk         (clk),
        .reset       (reset),
        .req         (req),
        .req_opcode  (req_opcode),
        .req_address (req_address),
        .req_wdata   (req_wdata),
        .gnt         (gnt),
        .done        (done),
        .err         (err),
        .rdata       (rdata),
        .busy        (busy),
        .l2_opcode   (l2_opcode),
        .l2_address  (l2_address),
        .l2_wdata    (l2_wdata),
        .l2_hit      (l2_hit),
        .l2_rdata    (l2_rdata)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    logic [1:0]  req_v;
    logic [6:0]  op_v [2];
    logic [31:0] ad_v [2];
    logic [31:0] wd_v [2];

    typedef struct {
        logic [1:0]  rq;
        logic [6:0]  op;
        logic [31:0] addr;
        logic [31:0] wd;
        int          core;
        int          k;
        bit          miss;
        int          m;
        logic [31:0] fill;
        int          off;
        bit          err;
        logic [31:0] rd;
        bit          drop;
    } vec_t;

    vec_t vecs [12];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive();
        req         = req_v;
        req_opcode  = {op_v[1], op_v[0]};
        req_address = {ad_v[1], ad_v[0]};
        req_wdata   = {wd_v[1], wd_v[0]};
    endtask

    // Reference timing: ISSUE and RESP take a cycle each, a miss adds the
    // cycles spent waiting for the fill, an unanswered miss waits TO cycles.
    function automatic bit fill_in_time(input bit miss, input int m);
        return miss && (m >= 1) && (m <= TO);
    endfunction

    function automatic int model_off(input logic [6:0] op, input int k, input bit miss, input int m);
        if (op != LD)                return 2;
        if (!miss)                   return k + 2;
        if (fill_in_time(miss, m))   return k + m + 2;
        return k + TO + 2;
    endfunction

    function automatic bit model_err(input logic [6:0] op, input bit miss, input int m);
        return (op == LD) && miss && !fill_in_time(miss, m);
    endfunction

    task automatic run_txn(input string name, input int core, input int k, input bit miss,
                           input int m, input logic [31:0] fill, input int off, input bit xerr,
                           input logic [31:0] xrd, input bit drop);
        bit          got;
        bit          hold_ok;
        logic [1:0]  onehot;
        logic [1:0]  hit_v;
        got     = 1'b0;
        hold_ok = 1'b1;
        onehot  = (core == 1) ? 2'b10 : 2'b01;
        for (int i = 0; i < 6 && !got; i++) begin
            @(posedge clk); #1;
            got = (gnt != 2'b00);
        end
        check({name, " gnt"}, 128'(gnt), 128'(onehot));
        if (!got) return;
        for (int t = 0; t <= off; t++) begin
            if (t > 0) begin
                @(posedge clk); #1;
                if (gnt != 2'b00) hold_ok = 1'b0;
            end
            if (t <= off - 2) begin
                if (l2_opcode != op_v[core] || l2_address != ad_v[core] ||
                    l2_wdata != wd_v[core] || !busy || done != 2'b00) hold_ok = 1'b0;
            end else if (t == off - 1) begin
                if (l2_opcode != 7'd0 || l2_address != 32'd0 || l2_wdata != 32'd0 ||
                    !busy || done != 2'b00) hold_ok = 1'b0;
            end
            if (t < off) begin
                hit_v    = 2'b00;
                l2_rdata = $urandom;
                if (op_v[core] == LD) begin
                    if (t == k)                              hit_v = miss ? 2'b01 : 2'b10;
                    else if (miss && m > 0 && t == k + m)    hit_v = 2'b10;
                    if (hit_v == 2'b10)                      l2_rdata = fill;
                end else if (t == 0) begin
                    hit_v = 2'($urandom_range(0, 3));
                end
                l2_hit = hit_v;
                if (t == 0 && drop) begin
                    req_v[core] = 1'b0;
                    drive();
                end
            end else begin
                l2_hit = 2'b00;
                check({name, " done"}, 128'(done), 128'(onehot));
                check({name, " err"}, 128'(err), 128'(xerr ? onehot : 2'b00));
                check({name, " rdata"}, 128'(rdata), 128'(xrd));
                check({name, " idle"}, 128'({busy, l2_opcode, l2_address, l2_wdata}), 128'(0));
            end
        end
        check({name, " hold"}, 128'(hold_ok), 128'(1));
        req_v[core] = 1'b0;
        drive();
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin : main
        bit          g;
        bit          quiet;
        int          last;
        int          win;
        int          k;
        int          m;
        bit          miss;
        bit          drop;
        int          off;
        bit          xe;
        logic [31:0] fill;

        vecs[0]  = '{2'b11, LD,  32'h0000_0200, 32'h0,          0, 0, 1'b0, 0,  32'h0000_00A1, 2,  1'b0, 32'h0000_00A1, 1'b0};
        vecs[1]  = '{2'b11, LD,  32'h0000_0200, 32'h0,          1, 0, 1'b0, 0,  32'h0000_00A2, 2,  1'b0, 32'h0000_00A2, 1'b0};
        vecs[2]  = '{2'b11, LD,  32'h0000_0200, 32'h0,          0, 0, 1'b0, 0,  32'h0000_00A3, 2,  1'b0, 32'h0000_00A3, 1'b0};
        vecs[3]  = '{2'b01, LD,  32'h0000_0104, 32'h0,          0, 0, 1'b0, 0,  32'hDEAD_BEEF, 2,  1'b0, 32'hDEAD_BEEF, 1'b0};
        vecs[4]  = '{2'b10, LD,  32'h0000_0800, 32'h0,          1, 0, 1'b1, 5,  32'hCAFE_F00D, 7,  1'b0, 32'hCAFE_F00D, 1'b0};
        vecs[5]  = '{2'b01, LD,  32'h0000_0900, 32'h0,          0, 0, 1'b1, 0,  32'h0BAD_0BAD, 18, 1'b1, 32'h0,         1'b0};
        vecs[6]  = '{2'b11, LD,  32'h0000_0A00, 32'h0,          1, 0, 1'b0, 0,  32'h0000_0011, 2,  1'b0, 32'h0000_0011, 1'b0};
        vecs[7]  = '{2'b01, ST,  32'h0000_0300, 32'h1234_5678,  0, 0, 1'b0, 0,  32'h0,         2,  1'b0, 32'h0,         1'b0};
        vecs[8]  = '{2'b10, ALU, 32'h0000_0400, 32'h5555_AAAA,  1, 0, 1'b0, 0,  32'h0,         2,  1'b0, 32'h0,         1'b0};
        vecs[9]  = '{2'b01, LD,  32'h0000_0500, 32'h0,          0, 2, 1'b0, 0,  32'h0000_0055, 4,  1'b0, 32'h0000_0055, 1'b0};
        vecs[10] = '{2'b10, LD,  32'h0000_0600, 32'h0,          1, 0, 1'b1, 16, 32'h0000_0077, 18, 1'b0, 32'h0000_0077, 1'b0};
        vecs[11] = '{2'b01, LD,  32'h0000_0700, 32'h0,          0, 0, 1'b1, 15, 32'h0000_0066, 17, 1'b0, 32'h0000_0066, 1'b1};

        reset    = 1'b0;
        req_v    = 2'b00;
        for (int c = 0; c < 2; c++) begin
            op_v[c] = '0;
            ad_v[c] = '0;
            wd_v[c] = '0;
        end
        drive();
        l2_hit   = 2'b00;
        l2_rdata = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset state", 128'({gnt, done, err, rdata, busy, l2_opcode, l2_address, l2_wdata}), 128'(0));
        #4 reset = 1'b1;

        for (int i = 0; i < 12; i++) begin
            req_v = vecs[i].rq;
            for (int c = 0; c < 2; c++) begin
                op_v[c] = vecs[i].op;
                ad_v[c] = vecs[i].addr + 32'(c) * 32'h100;
                wd_v[c] = vecs[i].wd ^ 32'(c);
            end
            drive();
            run_txn($sformatf("vec%0d", i), vecs[i].core, vecs[i].k, vecs[i].miss, vecs[i].m,
                    vecs[i].fill, vecs[i].off, vecs[i].err, vecs[i].rd, vecs[i].drop);
        end

        req_v   = 2'b10;
        op_v[1] = LD;
        ad_v[1] = 32'h0000_4000;
        drive();
        g = 1'b0;
        for (int i = 0; i < 6 && !g; i++) begin
            @(posedge clk); #1;
            g = (gnt != 2'b00);
        end
        check("rst gnt", 128'(gnt), 128'(2'b10));
        l2_hit = 2'b01;
        @(posedge clk); #1;
        l2_hit = 2'b00;
        @(posedge clk); #1;
        @(posedge clk); #3;
        reset = 1'b0;
        #1;
        check("rst async", 128'({gnt, done, err, rdata, busy, l2_opcode, l2_address, l2_wdata}), 128'(0));
        req_v = 2'b00;
        drive();
        repeat (2) @(posedge clk);
        #2 reset = 1'b1;
        quiet = 1'b0;
        repeat (4) begin
            @(posedge clk); #1;
            quiet = quiet | (|done) | busy;
        end
        check("rst no done", 128'(quiet), 128'(0));
        req_v   = 2'b10;
        ad_v[1] = 32'h0000_4100;
        drive();
        run_txn("post rst", 1, 0, 1'b0, 0, 32'hBEEF_0001, 2, 1'b0, 32'hBEEF_0001, 1'b0);
        last = 1;

        for (int it = 0; it < 40; it++) begin
            for (int c = 0; c < 2; c++) begin
                if (!req_v[c] && ($urandom % 2 == 0)) begin
                    req_v[c] = 1'b1;
                    case ($urandom % 8)
                        0, 1, 2, 3, 4: op_v[c] = LD;
                        5, 6:          op_v[c] = ST;
                        default:       op_v[c] = 7'($urandom);
                    endcase
                    ad_v[c] = $urandom;
                    wd_v[c] = $urandom;
                end
            end
            if (req_v == 2'b00) begin
                req_v[0] = 1'b1;
                op_v[0]  = LD;
                ad_v[0]  = $urandom;
                wd_v[0]  = $urandom;
            end
            drive();
            win  = (req_v == 2'b11) ? (1 - last) : (req_v[1] ? 1 : 0);
            k    = int'($urandom_range(0, 2));
            miss = 1'($urandom % 2);
            m    = int'($urandom_range(0, TO));
            drop = 1'($urandom % 2);
            fill = $urandom;
            off  = model_off(op_v[win], k, miss, m);
            xe   = model_err(op_v[win], miss, m);
            run_txn($sformatf("rand%0d", it), win, k, miss, m, fill, off, xe,
                    ((op_v[win] == LD) && !xe) ? fill : 32'h0, drop);
            last = win;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
